// File: rtl/bp_me_mock_pkg.sv
// Shared types for the mock memory endpoint: opcodes, trace packet layout, FSM states, size decode.
// Trace output on response handshakes is compiled in only with MOCK_LCE_ME_TRACE_EN defined.
package bp_me_mock_pkg;

    localparam int me_paddr_width_lp  = 40;
    localparam int me_dword_width_lp  = 64;
    localparam int me_opcode_width_lp = 4;

    typedef enum logic [3:0] {
        OP_LB  = 4'd0,
        OP_LH  = 4'd1,
        OP_LW  = 4'd2,
        OP_LD  = 4'd3,
        OP_LBU = 4'd4,
        OP_LHU = 4'd5,
        OP_LWU = 4'd6,
        OP_SB  = 4'd8,
        OP_SH  = 4'd9,
        OP_SW  = 4'd10,
        OP_SD  = 4'd11
    } me_opcode_e;

    // Opcode is a raw field so that NOP encodings can travel through the same type.
    typedef struct packed {
        logic [me_opcode_width_lp-1:0] opcode;
        logic [me_paddr_width_lp-1:0]  paddr;
        logic [me_dword_width_lp-1:0]  data;
    } me_pkt_t;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } me_state_e;

    // log2 of access size in bytes; the low two opcode bits encode it for every load/store.
    function automatic logic [1:0] op_size(input logic [3:0] op);
        return op[1:0];
    endfunction

endpackage

// File: rtl/mock_lce_me_if.sv
// Trace request/response channel between a trace-node master and the mock memory endpoint.
interface mock_lce_me_if #(
    parameter int ring_width_p = 108
) ();
    logic [ring_width_p-1:0] req_pkt;
    logic                    req_v;
    logic                    req_yumi;
    logic [ring_width_p-1:0] resp_pkt;
    logic                    resp_v;
    logic                    resp_ready;

    modport master (
        output req_pkt, req_v, resp_ready,
        input  req_yumi, resp_pkt, resp_v
    );

    modport slave (
        input  req_pkt, req_v, resp_ready,
        output req_yumi, resp_pkt, resp_v
    );
endinterface

// File: rtl/bp_me_mock_mem.sv
// 1RW dword RAM with synchronous byte-masked write and asynchronous read; contents survive reset.
module bp_me_mock_mem #(
    parameter int els_p    = 1024,
    parameter int addr_w_p = $clog2(els_p)
) (
    input  logic                clk_i,
    input  logic                w_en,
    input  logic [addr_w_p-1:0] addr,
    input  logic [63:0]         w_data,
    input  logic [7:0]          w_mask,
    output logic [63:0]         r_data
);
    logic [63:0] mem [els_p];

    always_ff @(posedge clk_i) begin
        if (w_en) begin
            for (int b = 0; b < 8; b++) begin
                if (w_mask[b]) begin
                    mem[addr][b*8 +: 8] <= w_data[b*8 +: 8];
                end
            end
        end
    end

    assign r_data = mem[addr];
endmodule

// File: rtl/mock_lce_me.sv
// Mock memory endpoint: one trace packet in, load/store on a dword RAM after mem_latency_p cycles, one response out.
// Optional response trace printing is enabled by defining MOCK_LCE_ME_TRACE_EN.
module mock_lce_me
    import bp_me_mock_pkg::*;
#(
    parameter int paddr_width_p   = 40,
    parameter int dword_width_p   = 64,
    parameter int opcode_width_p  = 4,
    parameter int mem_els_p       = 1024,
    parameter int mem_latency_p   = 2,
    parameter int skip_ram_init_p = 1,
    localparam int ring_width_lp  = opcode_width_p + paddr_width_p + dword_width_p
) (
    input logic          clk_i,
    input logic          reset_n_i,
    mock_lce_me_if.slave tr
);
    localparam int idx_w_lp = $clog2(mem_els_p);
    localparam int lat_w_lp = $clog2(mem_latency_p + 1);

    me_state_e                state;
    logic [idx_w_lp-1:0]      init_cnt;
    logic [lat_w_lp-1:0]      lat_cnt;
    logic [ring_width_lp-1:0] req_q;
    logic [ring_width_lp-1:0] resp_pkt_q;
    logic                     resp_v_q;

    logic [opcode_width_p-1:0] op_q;
    logic [paddr_width_p-1:0]  paddr_q;
    logic [dword_width_p-1:0]  data_q;
    logic [3:0]                opc4;
    logic                      op_hi_zero, is_load, is_store, is_signed;
    logic [1:0]                size;
    logic [2:0]                al_off;
    logic [5:0]                shamt;
    logic [63:0]               rd_data, shifted, load_data, st_data, resp_data;
    logic [7:0]                st_mask;
    logic                      init_active, access_last;
    logic                      mem_w_en;
    logic [idx_w_lp-1:0]       mem_addr;
    logic [63:0]               mem_w_data;
    logic [7:0]                mem_w_mask;

    assign op_q    = req_q[ring_width_lp-1 -: opcode_width_p];
    assign paddr_q = req_q[dword_width_p +: paddr_width_p];
    assign data_q  = req_q[dword_width_p-1:0];

    assign opc4       = op_q[3:0];
    assign op_hi_zero = ((op_q >> 4) == '0);
    assign is_load    = op_hi_zero && (opc4 <= 4'd6);
    assign is_store   = op_hi_zero && (opc4[3:2] == 2'b10);
    assign is_signed  = (opc4 == OP_LB) || (opc4 == OP_LH) || (opc4 == OP_LW);

    always_comb begin
        size = op_size(opc4);
        case (size)
            2'd0:    al_off = paddr_q[2:0];
            2'd1:    al_off = {paddr_q[2:1], 1'b0};
            2'd2:    al_off = {paddr_q[2], 2'b00};
            default: al_off = 3'b000;
        endcase
        shamt   = {al_off, 3'b000};
        shifted = rd_data >> shamt;
        st_data = data_q << shamt;
        case (size)
            2'd0: begin
                load_data = is_signed ? {{56{shifted[7]}}, shifted[7:0]} : {56'd0, shifted[7:0]};
                st_mask   = 8'h01 << al_off;
            end
            2'd1: begin
                load_data = is_signed ? {{48{shifted[15]}}, shifted[15:0]} : {48'd0, shifted[15:0]};
                st_mask   = 8'h03 << al_off;
            end
            2'd2: begin
                load_data = is_signed ? {{32{shifted[31]}}, shifted[31:0]} : {32'd0, shifted[31:0]};
                st_mask   = 8'h0F << al_off;
            end
            default: begin
                load_data = shifted;
                st_mask   = 8'hFF;
            end
        endcase
        resp_data = is_load ? load_data : 64'd0;
    end

    // The init sweep borrows the single RAM port; a pending request waits because yumi is gated to IDLE.
    assign init_active = (state == ST_INIT);
    assign access_last = (state == ST_ACCESS) && (lat_cnt == lat_w_lp'(mem_latency_p - 1));
    assign mem_w_en    = init_active || (access_last && is_store);
    assign mem_addr    = init_active ? init_cnt : paddr_q[3 +: idx_w_lp];
    assign mem_w_data  = init_active ? 64'(init_cnt) : st_data;
    assign mem_w_mask  = init_active ? 8'hFF : st_mask;

    bp_me_mock_mem #(.els_p(mem_els_p)) u_mem (
        .clk_i  (clk_i),
        .w_en   (mem_w_en),
        .addr   (mem_addr),
        .w_data (mem_w_data),
        .w_mask (mem_w_mask),
        .r_data (rd_data)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state      <= (skip_ram_init_p != 0) ? ST_IDLE : ST_INIT;
            init_cnt   <= '0;
            lat_cnt    <= '0;
            req_q      <= '0;
            resp_pkt_q <= '0;
            resp_v_q   <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == idx_w_lp'(mem_els_p - 1)) state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (tr.req_v) begin
                        req_q   <= tr.req_pkt;
                        lat_cnt <= '0;
                        state   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    lat_cnt <= lat_cnt + 1'b1;
                    if (access_last) begin
                        resp_pkt_q <= {op_q, paddr_q, resp_data};
                        resp_v_q   <= 1'b1;
                        state      <= ST_RESP;
                    end
                end
                default: begin
                    if (tr.resp_ready) begin
                        resp_v_q <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign tr.req_yumi = (state == ST_IDLE) && tr.req_v;
    assign tr.resp_v   = resp_v_q;
    assign tr.resp_pkt = resp_pkt_q;

`ifdef MOCK_LCE_ME_TRACE_EN
    always @(posedge clk_i) begin
        if (resp_v_q && tr.resp_ready)
            $display("[%0t] op=%h addr=%h data=%h", $time,
                     resp_pkt_q[ring_width_lp-1 -: opcode_width_p],
                     resp_pkt_q[dword_width_p +: paddr_width_p],
                     resp_pkt_q[dword_width_p-1:0]);
    end
`else
    // Trace printing compiled out; timing is unaffected either way.
`endif

endmodule

// File: tb/tb_mock_lce_me.sv
// Directed bench for mock_lce_me: init sweep, load/store sizing and extension, wrap, NOP, backpressure, reset abort.
module tb_mock_lce_me;
    import bp_me_mock_pkg::*;

    localparam int els_lp  = 64;
    localparam int ring_lp = 108;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   compared = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    mock_lce_me_if #(.ring_width_p(ring_lp)) bus ();

    mock_lce_me #(
        .paddr_width_p  (40),
        .dword_width_p  (64),
        .opcode_width_p (4),
        .mem_els_p      (els_lp),
        .mem_latency_p  (2),
        .skip_ram_init_p(0)
    ) dut (
        .clk_i    (clk),
        .reset_n_i(reset_n),
        .tr       (bus.slave)
    );

    task automatic check(input string tag, input logic [107:0] obs, input logic [107:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request (called just after a negedge), check latency, echoed header and data.
    task automatic txn(input string tag, input logic [3:0] op, input logic [39:0] addr,
                       input logic [63:0] data, input logic [63:0] exp);
        int n;
        bus.req_pkt = {op, addr, data};
        bus.req_v   = 1'b1;
        #1;
        n = 0;
        while (!bus.req_yumi && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.req_yumi) begin
            check({tag, "_yumi_timeout"}, 108'(bus.req_yumi), 108'(1));
            bus.req_v = 1'b0;
            return;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) bus.req_v = 1'b0;
        end while (!bus.resp_v && n < 20);
        check({tag, "_latency"}, 108'(n), 108'(3));
        check({tag, "_hdr"}, 108'(bus.resp_pkt[107:64]), 108'({op, addr}));
        check({tag, "_data"}, 108'(bus.resp_pkt[63:0]), 108'(exp));
        if (bus.resp_ready) @(negedge clk);
    endtask

    initial begin
        logic [107:0] held;
        bus.req_pkt    = '0;
        bus.req_v      = 1'b0;
        bus.resp_ready = 1'b1;
        #1;
        check("rst_resp_v", 108'(bus.resp_v), 108'(0));
        check("rst_resp_pkt", bus.resp_pkt, 108'(0));
        bus.req_pkt = {4'd3, 40'h18, 64'd0};
        bus.req_v   = 1'b1;
        #1;
        check("rst_yumi", 108'(bus.req_yumi), 108'(0));
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("init_no_yumi", 108'(bus.req_yumi), 108'(0));
        @(negedge clk);

        txn("ld_init",  4'd3,  40'h18,  64'd0, 64'h3);
        txn("sd_40",    4'd11, 40'h40,  64'h8877665544332211, 64'd0);
        txn("lb_41",    4'd0,  40'h41,  64'd0, 64'h22);
        txn("lbu_47",   4'd4,  40'h47,  64'd0, 64'h88);
        txn("lb_47",    4'd0,  40'h47,  64'd0, 64'hFFFFFFFFFFFFFF88);
        txn("lh_46",    4'd1,  40'h46,  64'd0, 64'hFFFFFFFFFFFF8877);
        txn("lhu_47",   4'd5,  40'h47,  64'd0, 64'h8877);
        txn("sw_104",   4'd10, 40'h104, 64'hDEADBEEF, 64'd0);
        txn("lw_104",   4'd2,  40'h104, 64'd0, 64'hFFFFFFFFDEADBEEF);
        txn("lwu_104",  4'd6,  40'h104, 64'd0, 64'hDEADBEEF);
        txn("ld_100",   4'd3,  40'h100, 64'd0, 64'hDEADBEEF00000020);
        txn("ld_wrap",  4'd3,  40'h40 + 40'(els_lp * 8), 64'd0, 64'h8877665544332211);
        txn("nop_7",    4'd7,  40'h40,  64'h1234, 64'd0);
        txn("ld_nop",   4'd3,  40'h40,  64'd0, 64'h8877665544332211);
        txn("sh_43",    4'd9,  40'h43,  64'hAAAABBCC, 64'd0);
        txn("ld_sh",    4'd3,  40'h40,  64'd0, 64'h88776655BBCC2211);

        // Backpressure: response must hold while ready is low and no new request may be taken.
        bus.resp_ready = 1'b0;
        txn("bp_ld", 4'd3, 40'h28, 64'd0, 64'h5);
        held = bus.resp_pkt;
        bus.req_pkt = {4'd3, 40'h30, 64'd0};
        bus.req_v   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("bp_v_held", 108'(bus.resp_v), 108'(1));
            check("bp_pkt_stable", bus.resp_pkt, held);
            check("bp_no_yumi", 108'(bus.req_yumi), 108'(0));
        end
        bus.req_v      = 1'b0;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check("bp_released", 108'(bus.resp_v), 108'(0));

        // Reset during the first ACCESS cycle of a store aborts it.
        bus.req_pkt = {4'd11, 40'h8, 64'hFFFFFFFFFFFFFFFF};
        bus.req_v   = 1'b1;
        #1;
        check("abort_yumi", 108'(bus.req_yumi), 108'(1));
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort_v", 108'(bus.resp_v), 108'(0));
        check("abort_pkt", bus.resp_pkt, 108'(0));
        check("abort_no_yumi", 108'(bus.req_yumi), 108'(0));
        @(negedge clk);
        bus.req_v = 1'b0;
        reset_n   = 1'b1;
        @(negedge clk);
        txn("post_rst_ld", 4'd3, 40'h8, 64'd0, 64'h1);
        txn("post_rst_lbu", 4'd4, 40'h1F, 64'd0, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
